// File: rtl/busca_instrucao_if.sv
// Fetch-stage bus: ROM read, control-unit decision, register-file targets,
// operator button, and the stage's status/strobe outputs.
interface busca_instrucao_if #(
   parameter int unsigned ADDR_W = 8
);
   logic [31:0]       instr_data;
   logic [1:0]        UC_counter;
   logic [1:0]        UC_mult03;
   logic [31:0]       reg_jump;
   logic [31:0]       reg_branch_alvo;
   logic              confirma;
   logic [ADDR_W-1:0] instr_addr;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       instrucao;
   logic [4:0]        opcode;
   logic              exec_en;
   logic              aguardando;
   logic              parado;

   // Environment side: ROM, control unit, register file, operator panel.
   modport master (
      output instr_data, UC_counter, UC_mult03, reg_jump, reg_branch_alvo, confirma,
      input  instr_addr, pc, instrucao, opcode, exec_en, aguardando, parado
   );

   // Fetch stage side.
   modport slave (
      input  instr_data, UC_counter, UC_mult03, reg_jump, reg_branch_alvo, confirma,
      output instr_addr, pc, instrucao, opcode, exec_en, aguardando, parado
   );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch / program-counter stage. Latches the IR from the ROM,
// hands the opcode to the combinational control unit, applies its next-PC
// decision, and owns the HALT state and the IN-instruction button wait.
module busca_instrucao #(
   parameter int unsigned ADDR_W = 8,
   parameter logic [4:0]  OP_IN  = 5'b00111
) (
   input logic               clock,
   input logic               reset,
   busca_instrucao_if.slave  bus
);

   localparam logic [1:0] StFetch  = 2'd0;
   localparam logic [1:0] StExec   = 2'd1;
   localparam logic [1:0] StWaitIn = 2'd2;
   localparam logic [1:0] StHalt   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] jump_tgt;
   logic [ADDR_W-1:0] next_pc;
   logic [1:0]        sync_q;
   logic              sync_prev_q;
   logic              edge_q;
   logic              exec_en;

   assign pc_inc = pc_q + ADDR_W'(1);

   // Jump target selection; the reserved select falls back to sequential flow.
   always_comb begin
      case (bus.UC_mult03)
         2'b00:   jump_tgt = ir_q[ADDR_W-1:0];
         2'b01:   jump_tgt = bus.reg_jump[ADDR_W-1:0];
         2'b10:   jump_tgt = bus.reg_branch_alvo[ADDR_W-1:0];
         default: jump_tgt = pc_inc;
      endcase
   end

   assign next_pc = (bus.UC_counter == 2'b01) ? jump_tgt : pc_inc;

   // Next-state logic; UC_* only matter in EXEC.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      exec_en = 1'b0;
      case (state_q)
         StFetch: begin
            ir_d    = bus.instr_data;
            state_d = StExec;
         end
         StExec: begin
            if (ir_q[31:27] == OP_IN) begin
               state_d = StWaitIn;
            end else if (bus.UC_counter == 2'b11) begin
               state_d = StHalt;
            end else begin
               exec_en = 1'b1;
               pc_d    = next_pc;
               state_d = StFetch;
            end
         end
         StWaitIn: begin
            // edge_q is registered, so confirma never reaches an output combinationally.
            if (edge_q) begin
               exec_en = 1'b1;
               pc_d    = pc_inc;
               state_d = StFetch;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
      endcase
   end

   // Architectural state: FSM, PC and instruction register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Button synchronizer and rising-edge detector. Runs in every state so a
   // button already held when WAIT_IN is entered has no pending edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q      <= '0;
         sync_prev_q <= 1'b0;
         edge_q      <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], bus.confirma};
         sync_prev_q <= sync_q[1];
         edge_q      <= sync_q[1] & ~sync_prev_q;
      end
   end

   assign bus.instr_addr = pc_q;
   assign bus.pc         = pc_q;
   assign bus.instrucao  = ir_q;
   assign bus.opcode     = ir_q[31:27];
   assign bus.exec_en    = exec_en;
   assign bus.aguardando = (state_q == StWaitIn);
   assign bus.parado     = (state_q == StHalt);

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: a scoreboard of expected executions built from a
// program-level model, checked by an independent monitor, plus directed
// IN/HALT/reset scenarios.
module tb_busca_instrucao;

   localparam int unsigned AW = 8;
   localparam logic [31:0] ADD_I = {5'b00001, 27'h0};
   localparam logic [31:0] IN_I  = {5'b00111, 27'h0};

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   busca_instrucao_if #(.ADDR_W(AW)) bus ();

   busca_instrucao #(.ADDR_W(AW), .OP_IN(5'b00111)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Environment: ROM, control-unit decision table, register values, button.
   logic [31:0] rom    [256];
   logic [1:0]  uc_cnt [256];
   logic [1:0]  uc_mux [256];
   logic [31:0] reg_jump_v;
   logic [31:0] reg_branch_v;
   logic        confirma = 1'b0;

   assign bus.instr_data      = rom[bus.instr_addr];
   assign bus.UC_counter      = uc_cnt[bus.pc];
   assign bus.UC_mult03       = uc_mux[bus.pc];
   assign bus.reg_jump        = reg_jump_v;
   assign bus.reg_branch_alvo = reg_branch_v;
   assign bus.confirma        = confirma;

   typedef struct packed {
      logic [7:0]  pc;
      logic [31:0] ir;
      logic [7:0]  nxt;
      logic        chk_gap;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   glitch_cnt = 0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: every exec_en strobe must match the head of the scoreboard.
   logic       pend = 1'b0;
   logic [7:0] pend_nxt;
   int         since = 0;
   bit         have_last = 1'b0;
   exp_t       mon_e;
   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            pend      = 1'b0;
            have_last = 1'b0;
            since     = 0;
         end else begin
            since++;
            if (bus.parado || bus.aguardando) glitch_cnt++;
            if (pend) begin
               check("next_pc", bus.pc, pend_nxt);
               pend = 1'b0;
            end
            if (bus.exec_en) begin
               if (sb_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_exec: got exec_en at pc %0h expected none", bus.pc);
               end else begin
                  mon_e = sb_q.pop_front();
                  check("exec_pc", bus.pc, mon_e.pc);
                  check("exec_ir", bus.instrucao, mon_e.ir);
                  check("exec_opcode", bus.opcode, mon_e.ir[31:27]);
                  if (mon_e.chk_gap && have_last) check("exec_gap", since, 2);
                  pend     = 1'b1;
                  pend_nxt = mon_e.nxt;
               end
               have_last = 1'b1;
               since     = 0;
            end
         end
      end
   end

   // Program-level model: walk n instructions (no IN/STOP) from pc 'start'.
   task automatic model_run(input int n, input logic [7:0] start);
      logic [7:0]  p;
      logic [7:0]  nxt;
      logic [31:0] ir;
      p = start;
      for (int i = 0; i < n; i++) begin
         ir = rom[p];
         nxt = p + 8'd1;
         if (uc_cnt[p] == 2'b01) begin
            if (uc_mux[p] == 2'b00) nxt = ir[7:0];
            else if (uc_mux[p] == 2'b01) nxt = reg_jump_v[7:0];
            else if (uc_mux[p] == 2'b10) nxt = reg_branch_v[7:0];
         end
         sb_q.push_back('{pc: p, ir: ir, nxt: nxt, chk_gap: 1'b1});
         p = nxt;
      end
   endtask

   task automatic push_exp(input logic [7:0] p, input logic [7:0] nxt, input logic gap);
      sb_q.push_back('{pc: p, ir: rom[p], nxt: nxt, chk_gap: gap});
   endtask

   // Wait until the scoreboard drains, then stop the DUT with reset.
   task automatic drain(input string name, input int budget);
      int c;
      c = 0;
      while ((sb_q.size() != 0 || pend) && c < budget) begin
         @(posedge clock);
         c++;
      end
      #1 reset = 1'b1;
      check(name, sb_q.size(), 0);
      sb_q.delete();
      repeat (2) @(negedge clock);
   endtask

   task automatic wait_flag(input string name, input bit halt, input int budget);
      int  c;
      bit  seen;
      c    = 0;
      seen = 1'b0;
      while (!seen && c < budget) begin
         @(negedge clock);
         seen = halt ? bus.parado : bus.aguardando;
         c++;
      end
      check(name, seen, 1);
   endtask

   task automatic fill_linear();
      for (int a = 0; a < 256; a++) begin
         rom[a]    = ADD_I;
         uc_cnt[a] = 2'b00;
         uc_mux[a] = 2'b00;
      end
   endtask

   initial begin
      int lat;
      int bad;
      reg_jump_v   = '0;
      reg_branch_v = '0;
      fill_linear();

      // Reset state.
      #12;
      check("rst_pc", bus.pc, 0);
      check("rst_ir", bus.instrucao, 0);
      check("rst_exec_en", bus.exec_en, 0);
      check("rst_aguardando", bus.aguardando, 0);
      check("rst_parado", bus.parado, 0);
      check("rst_instr_addr", bus.instr_addr, 0);

      // Directed program: sequential ADDs, IR jump, truncated reg jump, wrap.
      rom[5]        = {5'b00001, 19'h0, 8'h20};
      uc_cnt[5]     = 2'b01;
      uc_mux[5]     = 2'b00;
      uc_cnt[8'h20] = 2'b01;
      uc_mux[8'h20] = 2'b01;
      reg_jump_v    = 32'h0000_01F3;
      uc_cnt[8'hF3] = 2'b01;
      uc_mux[8'hF3] = 2'b10;
      reg_branch_v  = 32'h0000_03FF;
      model_run(12, 8'h00);
      glitch_cnt = 0;
      @(negedge clock) reset = 1'b0;
      drain("prog_a_drained", 100);
      check("prog_a_no_wait_halt", glitch_cnt, 0);

      // Randomized programs: random ROM, decisions and register targets.
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < 256; a++) begin
            rom[a] = $urandom;
            if (rom[a][31:27] == 5'b00111) rom[a][31:27] = 5'b00010;
            uc_cnt[a] = 2'($urandom_range(0, 2));
            uc_mux[a] = 2'($urandom_range(0, 3));
         end
         reg_jump_v   = $urandom;
         reg_branch_v = $urandom;
         model_run(40, 8'h00);
         glitch_cnt = 0;
         @(negedge clock) reset = 1'b0;
         drain("rand_drained", 200);
         check("rand_no_wait_halt", glitch_cnt, 0);
      end

      // IN at 2 with button held on entry, STOP at 4.
      fill_linear();
      rom[2]    = IN_I;
      uc_cnt[4] = 2'b11;
      confirma  = 1'b1;
      push_exp(8'd0, 8'd1, 1'b1);
      push_exp(8'd1, 8'd2, 1'b1);
      @(negedge clock) reset = 1'b0;
      wait_flag("enter_wait_in", 1'b0, 40);
      repeat (10) @(negedge clock);
      check("held_stays_wait", bus.aguardando, 1);
      check("held_pc", bus.pc, 2);
      confirma = 1'b0;
      repeat (5) @(negedge clock);
      push_exp(8'd2, 8'd3, 1'b0);
      push_exp(8'd3, 8'd4, 1'b1);
      confirma = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
         @(negedge clock);
         if (bus.exec_en) lat = k;
      end
      check("confirma_latency", lat, 3);
      wait_flag("enter_halt", 1'b1, 30);
      check("halt_pc", bus.pc, 4);
      check("halt_ir", bus.instrucao, rom[4]);
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (bus.exec_en || bus.pc != 8'd4 || !bus.parado) bad++;
      end
      check("halt_frozen_cycles", bad, 0);
      check("halt_queue_empty", sb_q.size(), 0);
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("async_rst_pc", bus.pc, 0);
      check("async_rst_parado", bus.parado, 0);

      // Reset during WAIT_IN with a press in flight.
      confirma = 1'b0;
      repeat (2) @(negedge clock);
      push_exp(8'd0, 8'd1, 1'b1);
      push_exp(8'd1, 8'd2, 1'b1);
      @(negedge clock) reset = 1'b0;
      wait_flag("reenter_wait_in", 1'b0, 40);
      repeat (5) @(negedge clock);
      confirma = 1'b1;
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("async_rst_aguardando", bus.aguardando, 0);
      confirma = 1'b0;
      repeat (2) @(negedge clock);
      push_exp(8'd0, 8'd1, 1'b1);
      push_exp(8'd1, 8'd2, 1'b1);
      @(negedge clock) reset = 1'b0;
      wait_flag("restart_wait_in", 1'b0, 40);
      repeat (10) @(negedge clock);
      check("no_stale_edge_pc", bus.pc, 2);
      check("no_stale_edge_wait", bus.aguardando, 1);
      check("restart_queue_empty", sb_q.size(), 0);
      push_exp(8'd2, 8'd3, 1'b0);
      push_exp(8'd3, 8'd4, 1'b1);
      confirma = 1'b1;
      wait_flag("final_halt", 1'b1, 40);
      check("final_halt_pc", bus.pc, 4);
      check("final_queue_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
